depth_tester: RTL

- Consumes the fragment stream produced by the rasterizer: per fragment, {z, y, x} in fixed point plus a 12-bit colour.
- Performs the per-pixel depth test against an internal depth buffer.
- Fragments that pass update the depth buffer and are written to the framebuffer write port.
- A sequenced clear initialises the depth buffer and framebuffer, both after reset and on request.

---
 rtl/depth_tester.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/depth_tester.sv
// depth_tester: per-pixel depth test of rasterizer fragments against an internal
//   depth buffer, with a sequenced clear of depth buffer and framebuffer.
// Latency: fragment accepted in cycle t writes the framebuffer in cycle t+4.
// Backpressure: none on fb outputs; ready_out drops only while draining/clearing.
// Ports: clk_in/rst_in (sync, active high); valid_in/ready_out/fragment_in/color_in
//   fragment input ({z,y,x}); clear_in/clear_color_in/clear_done_out clear control;
//   fb_we_out/fb_addr_out/fb_data_out framebuffer write port; drawn_count_out
//   passing fragments since last clear; error_out sticky fragment-while-not-ready.
module depth_tester #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int DEPTH_BITS = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [2:0][16:0] fragment_in,
  input  logic [11:0]      color_in,
  input  logic             clear_in,
  input  logic [11:0]      clear_color_in,
  output logic             clear_done_out,
  output logic             fb_we_out,
  output logic [16:0]      fb_addr_out,
  output logic [11:0]      fb_data_out,
  output logic [31:0]      drawn_count_out,
  output logic             error_out
);

  localparam int NPIX = H_RES * V_RES;
  localparam int AW   = $clog2(NPIX);
  localparam int CW   = $clog2(NPIX + 1);

  typedef enum logic [1:0] {S_READY, S_DRAIN, S_CLEAR} state_t;
  state_t state_q, state_d;

  // Fragment pipeline: s1 = address registered, s2/s3 = BRAM read in flight.
  logic                  s1_vld, s2_vld, s3_vld;
  logic [16:0]           s1_addr, s2_addr, s3_addr;
  logic [DEPTH_BITS-1:0] s1_z, s2_z, s3_z;
  logic [11:0]           s1_color, s2_color, s3_color;
  logic [DEPTH_BITS-1:0] rd_q1, rd_q2;
  logic [DEPTH_BITS-1:0] depth_mem [NPIX];

  // Writes of the three most recently compared fragments; [0] is the youngest.
  logic [2:0]            w_vld;
  logic [16:0]           w_addr [3];
  logic [DEPTH_BITS-1:0] w_z    [3];

  logic [CW-1:0] clr_addr;
  logic [11:0]   clr_color;

  logic [8:0]  px, py;
  logic [31:0] addr_full;
  logic        in_screen, accept, pipe_empty, clr_wr, clr_end, pass;
  logic [DEPTH_BITS-1:0] cmp_depth;

  assign px        = fragment_in[0][16:8];
  assign py        = fragment_in[1][16:8];
  assign in_screen = ({23'd0, px} < H_RES) && ({23'd0, py} < V_RES);
  assign accept    = valid_in && ready_out;

  generate
    if (H_RES == 320) begin : g_shift_add
      assign addr_full = ({23'd0, py} << 8) + ({23'd0, py} << 6) + {23'd0, px};
    end else begin : g_mult
      assign addr_full = {23'd0, py} * H_RES + {23'd0, px};
    end
  endgenerate

  // Fractional coordinate bits and the low depth bits are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{fragment_in[0][7:0], fragment_in[1][7:0], fragment_in[2],
                         addr_full[31:17]};

  assign pipe_empty = !s1_vld && !s2_vld && !s3_vld;
  // Clear writes addresses 0..NPIX-1; the extra cycle at NPIX lets the last
  // registered clear write be presented before returning to Ready.
  assign clr_wr  = (state_q == S_CLEAR) && (clr_addr != CW'(NPIX));
  assign clr_end = (state_q == S_CLEAR) && (clr_addr == CW'(NPIX));

  // BRAM data is stale for the fragments that write after this one's read was
  // issued, so the youngest matching older passing fragment overrides it.
  always_comb begin
    cmp_depth = rd_q2;
    for (int i = 2; i >= 0; i--) begin
      if (w_vld[i] && (w_addr[i] == s3_addr)) cmp_depth = w_z[i];
    end
  end

  assign pass = s3_vld && (s3_z < cmp_depth);

  always_comb begin
    state_d   = state_q;
    ready_out = 1'b0;
    case (state_q)
      S_READY: begin
        ready_out = 1'b1;
        if (clear_in) state_d = S_DRAIN;
      end
      S_DRAIN: if (pipe_empty) state_d = S_CLEAR;
      S_CLEAR: if (clr_end) state_d = S_READY;
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= S_CLEAR;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_vld          <= 1'b0;
      s2_vld          <= 1'b0;
      s3_vld          <= 1'b0;
      w_vld           <= '0;
      clr_addr        <= '0;
      clr_color       <= 12'h000;
      clear_done_out  <= 1'b0;
      fb_we_out       <= 1'b0;
      fb_addr_out     <= '0;
      fb_data_out     <= '0;
      drawn_count_out <= '0;
      error_out       <= 1'b0;
    end else begin
      s1_vld         <= accept && in_screen;
      s2_vld         <= s1_vld;
      s3_vld         <= s2_vld;
      w_vld          <= {w_vld[1:0], pass};
      clear_done_out <= clr_end;

      if (state_q == S_READY && clear_in) clr_color <= clear_color_in;

      if (state_q == S_DRAIN) clr_addr <= '0;
      else if (clr_wr)        clr_addr <= clr_addr + CW'(1);

      if (clr_wr) begin
        fb_we_out   <= 1'b1;
        fb_addr_out <= 17'(clr_addr);
        fb_data_out <= clr_color;
      end else begin
        fb_we_out <= pass;
        if (pass) begin
          fb_addr_out <= s3_addr;
          fb_data_out <= s3_color;
        end
      end

      if (clr_end)   drawn_count_out <= '0;
      else if (pass) drawn_count_out <= drawn_count_out + 32'd1;

      if (valid_in && !ready_out) error_out <= 1'b1;
    end
  end

  // Payload registers carry no reset; their valid bits qualify them.
  always_ff @(posedge clk_in) begin
    s1_addr   <= addr_full[16:0];
    s1_z      <= fragment_in[2][16 -: DEPTH_BITS];
    s1_color  <= color_in;
    s2_addr   <= s1_addr;
    s2_z      <= s1_z;
    s2_color  <= s1_color;
    s3_addr   <= s2_addr;
    s3_z      <= s2_z;
    s3_color  <= s2_color;
    w_addr[0] <= s3_addr;
    w_z[0]    <= s3_z;
    for (int i = 1; i < 3; i++) begin
      w_addr[i] <= w_addr[i-1];
      w_z[i]    <= w_z[i-1];
    end
  end

  // Depth buffer: read-first, two-cycle registered read.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      if (clr_wr)    depth_mem[clr_addr[AW-1:0]] <= '1;
      else if (pass) depth_mem[s3_addr[AW-1:0]]  <= s3_z;
    end
    rd_q1 <= depth_mem[s1_addr[AW-1:0]];
    rd_q2 <= rd_q1;
  end

endmodule
